// File: rtl/rect_flip_engine.sv
// rect_flip_engine: holds a ROWS x COLS bit matrix and services rectangle
// corner requests. FLIP inverts the four corners (r1,c1),(r1,c2),(r2,c1),(r2,c2);
// TEST only reports their pre-operation values. Each valid request walks
// IDLE -> ROW1 -> ROW2 -> DONE, touching one row per cycle. Invalid requests
// go straight to DONE with an error response.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   load_valid        replace the matrix with load_matrix (IDLE only)
//   load_matrix       matrix image, bit r*COLS+c is element (r,c)
//   req_valid/ready   request handshake; ready only in IDLE without a load
//   req_op            0 = FLIP, 1 = TEST
//   req_r1/r2/c1/c2   corner coordinates
//   rsp_valid         one-cycle response pulse
//   rsp_err           request rejected, matrix untouched (held)
//   rsp_corners       {m[r2][c2], m[r2][c1], m[r1][c2], m[r1][c1]} (held)
//   m_out             current matrix register
//   busy              engine is not IDLE
//   flip_cnt          successful FLIPs since reset, saturating
module rect_flip_engine #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned RW    = $clog2(ROWS),
    parameter int unsigned CW    = $clog2(COLS),
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_valid,
    input  logic [ROWS*COLS-1:0] load_matrix,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [RW-1:0]        req_r1,
    input  logic [RW-1:0]        req_r2,
    input  logic [CW-1:0]        req_c1,
    input  logic [CW-1:0]        req_c2,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [3:0]           rsp_corners,
    output logic [ROWS*COLS-1:0] m_out,
    output logic                 busy,
    output logic [CNT_W-1:0]     flip_cnt
);

    localparam int unsigned N = ROWS * COLS;
    localparam logic OP_FLIP = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q;
    logic [N-1:0]       matrix_q;
    logic               op_q;
    logic [RW-1:0]      r1_q;
    logic [RW-1:0]      r2_q;
    logic [CW-1:0]      c1_q;
    logic [CW-1:0]      c2_q;
    logic [1:0]         row1_bits_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [3:0]         rsp_corners_q;
    logic [CNT_W-1:0]   flip_cnt_q;

    logic               req_invalid_c;
    logic               accept_c;
    logic [RW-1:0]      row_c;
    logic [31:0]        idx1_c;
    logic [31:0]        idx2_c;
    logic [N-1:0]       shift1_c;
    logic [N-1:0]       shift2_c;
    logic               bit1_c;
    logic               bit2_c;
    logic [N-1:0]       row_mask_c;

    // Degenerate rectangles and out-of-range coordinates are rejected.
    always_comb begin
        req_invalid_c = (req_r1 == req_r2) || (req_c1 == req_c2) ||
                        (32'(req_r1) >= ROWS) || (32'(req_r2) >= ROWS) ||
                        (32'(req_c1) >= COLS) || (32'(req_c2) >= COLS);
    end

    // Load wins over a request presented in the same IDLE cycle.
    assign req_ready = (state_q == IDLE) && !load_valid;
    assign accept_c  = req_valid && req_ready;

    // Corner access for the row being processed this cycle.
    always_comb begin
        row_c      = (state_q == ROW1) ? r1_q : r2_q;
        idx1_c     = 32'(row_c) * COLS + 32'(c1_q);
        idx2_c     = 32'(row_c) * COLS + 32'(c2_q);
        shift1_c   = matrix_q >> idx1_c;
        shift2_c   = matrix_q >> idx2_c;
        bit1_c     = shift1_c[0];
        bit2_c     = shift2_c[0];
        row_mask_c = (N'(1) << idx1_c) | (N'(1) << idx2_c);
    end

    // Control, matrix update and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            matrix_q      <= '0;
            op_q          <= 1'b0;
            r1_q          <= '0;
            r2_q          <= '0;
            c1_q          <= '0;
            c2_q          <= '0;
            row1_bits_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_corners_q <= '0;
            flip_cnt_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        matrix_q <= load_matrix;
                    end else if (accept_c) begin
                        op_q <= req_op;
                        r1_q <= req_r1;
                        r2_q <= req_r2;
                        c1_q <= req_c1;
                        c2_q <= req_c2;
                        if (req_invalid_c) begin
                            state_q       <= DONE;
                            rsp_valid_q   <= 1'b1;
                            rsp_err_q     <= 1'b1;
                            rsp_corners_q <= '0;
                        end else begin
                            state_q <= ROW1;
                        end
                    end
                end
                ROW1: begin
                    row1_bits_q <= {bit2_c, bit1_c};
                    if (op_q == OP_FLIP) begin
                        matrix_q <= matrix_q ^ row_mask_c;
                    end
                    state_q <= ROW2;
                end
                ROW2: begin
                    // Response and counter land together so they are visible in DONE.
                    rsp_corners_q <= {bit2_c, bit1_c, row1_bits_q};
                    rsp_err_q     <= 1'b0;
                    rsp_valid_q   <= 1'b1;
                    if (op_q == OP_FLIP) begin
                        matrix_q <= matrix_q ^ row_mask_c;
                        if (flip_cnt_q != '1) begin
                            flip_cnt_q <= flip_cnt_q + CNT_W'(1);
                        end
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_corners = rsp_corners_q;
    assign m_out       = matrix_q;
    assign busy        = (state_q != IDLE);
    assign flip_cnt    = flip_cnt_q;

endmodule

// File: tb/tb_rect_flip_engine.sv
// Self-checking bench for rect_flip_engine: a 4x4 instance exercised with
// directed and randomized operations against an array-based reference model,
// plus a 3x4 instance with a 2-bit counter for range and saturation cases.
module tb_rect_flip_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    // 4x4 instance
    logic        load_valid;
    logic [15:0] load_matrix;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [1:0]  req_r1, req_r2, req_c1, req_c2;
    logic        rsp_valid;
    logic        rsp_err;
    logic [3:0]  rsp_corners;
    logic [15:0] m_out;
    logic        busy;
    logic [15:0] flip_cnt;

    // 3x4 instance, 2-bit counter
    logic        s_load_valid;
    logic [11:0] s_load_matrix;
    logic        s_req_valid;
    logic        s_req_ready;
    logic        s_req_op;
    logic [1:0]  s_r1, s_r2, s_c1, s_c2;
    logic        s_rsp_valid;
    logic        s_rsp_err;
    logic [3:0]  s_rsp_corners;
    logic [11:0] s_m_out;
    logic        s_busy;
    logic [1:0]  s_flip_cnt;

    rect_flip_engine #(.ROWS(4), .COLS(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_matrix(load_matrix),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_r1(req_r1), .req_r2(req_r2), .req_c1(req_c1), .req_c2(req_c2),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_corners(rsp_corners),
        .m_out(m_out), .busy(busy), .flip_cnt(flip_cnt)
    );

    rect_flip_engine #(.ROWS(3), .COLS(4), .CNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n),
        .load_valid(s_load_valid), .load_matrix(s_load_matrix),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_op(s_req_op),
        .req_r1(s_r1), .req_r2(s_r2), .req_c1(s_c1), .req_c2(s_c2),
        .rsp_valid(s_rsp_valid), .rsp_err(s_rsp_err), .rsp_corners(s_rsp_corners),
        .m_out(s_m_out), .busy(s_busy), .flip_cnt(s_flip_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model of the 4x4 instance
    bit          mm [4][4];
    int unsigned mcnt;

    function automatic logic [15:0] pack_m();
        logic [15:0] p;
        p = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                p[r*4+c] = mm[r][c];
        return p;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mm[r][c] = 1'b0;
        mcnt = 0;
    endtask

    task automatic model_op(input bit op, input int r1, input int r2, input int c1, input int c2,
                            output int lat, output logic err, output logic [3:0] cor,
                            output logic [15:0] mid, output logic [15:0] fin, output logic [15:0] cnt);
        bit ok;
        ok = (r1 != r2) && (c1 != c2) && (r1 < 4) && (r2 < 4) && (c1 < 4) && (c2 < 4);
        if (!ok) begin
            lat = 1; err = 1'b1; cor = 4'b0000;
            mid = pack_m(); fin = pack_m();
        end else begin
            lat = 3; err = 1'b0;
            cor = {mm[r2][c2], mm[r2][c1], mm[r1][c2], mm[r1][c1]};
            if (!op) begin
                mm[r1][c1] = ~mm[r1][c1];
                mm[r1][c2] = ~mm[r1][c2];
            end
            mid = pack_m();
            if (!op) begin
                mm[r2][c1] = ~mm[r2][c1];
                mm[r2][c2] = ~mm[r2][c2];
                if (mcnt < 65535) mcnt++;
            end
            fin = pack_m();
        end
        cnt = 16'(mcnt);
    endtask

    task automatic do_load(input logic [15:0] img);
        load_valid  = 1'b1;
        load_matrix = img;
        @(posedge clk); #1;
        load_valid = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mm[r][c] = img[r*4+c];
    endtask

    // Issues one request from IDLE; returns at the response cycle (or after a bounded wait).
    task automatic run_op(input bit op, input int r1, input int r2, input int c1, input int c2,
                          output int lat, output logic err, output logic [3:0] cor,
                          output logic [15:0] mid, output logic [15:0] fin, output logic [15:0] cnt);
        req_op = op; req_r1 = 2'(r1); req_r2 = 2'(r2); req_c1 = 2'(c1); req_c2 = 2'(c2);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; err = 1'bx; cor = 4'bx; fin = 16'bx; cnt = 16'bx;
        mid = m_out;
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) mid = m_out;
            if (rsp_valid === 1'b1) begin
                lat = i; err = rsp_err; cor = rsp_corners; fin = m_out; cnt = flip_cnt;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op_small(input bit op, input int r1, input int r2, input int c1, input int c2,
                                output int lat, output logic err, output logic [3:0] cor,
                                output logic [11:0] fin, output logic [1:0] cnt);
        s_req_op = op; s_r1 = 2'(r1); s_r2 = 2'(r2); s_c1 = 2'(c1); s_c2 = 2'(c2);
        s_req_valid = 1'b1;
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        lat = -1; err = 1'bx; cor = 4'bx; fin = 12'bx; cnt = 2'bx;
        for (int i = 1; i <= 8; i++) begin
            if (s_rsp_valid === 1'b1) begin
                lat = i; err = s_rsp_err; cor = s_rsp_corners; fin = s_m_out; cnt = s_flip_cnt;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_valid = 1'b0; load_matrix = '0; req_valid = 1'b0; req_op = 1'b0;
        req_r1 = '0; req_r2 = '0; req_c1 = '0; req_c2 = '0;
        s_load_valid = 1'b0; s_load_matrix = '0; s_req_valid = 1'b0; s_req_op = 1'b0;
        s_r1 = '0; s_r2 = '0; s_c1 = '0; s_c2 = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (m_out !== 16'h0) begin fails++; $display("FAIL reset_m_out: got %h expected %h", m_out, 16'h0); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        tests++; if (rsp_corners !== 4'h0) begin fails++; $display("FAIL reset_corners: got %b expected 0000", rsp_corners); end
        tests++; if (flip_cnt !== 16'h0) begin fails++; $display("FAIL reset_flip_cnt: got %0d expected 0", flip_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        tests++; if (s_m_out !== 12'h0) begin fails++; $display("FAIL reset_small_m_out: got %h expected 000", s_m_out); end
        tests++; if (s_req_ready !== 1'b1) begin fails++; $display("FAIL reset_small_req_ready: got %b expected 1", s_req_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_flip_directed();
        int lat, e_lat; logic err, e_err; logic [3:0] cor, e_cor;
        logic [15:0] mid, e_mid, fin, e_fin, cnt, e_cnt;
        do_load(16'h0000);
        model_op(1'b0, 0, 2, 1, 3, e_lat, e_err, e_cor, e_mid, e_fin, e_cnt);
        run_op(1'b0, 0, 2, 1, 3, lat, err, cor, mid, fin, cnt);
        tests++; if (lat !== 3) begin fails++; $display("FAIL flip1_latency: got %0d expected 3", lat); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL flip1_err: got %b expected 0", err); end
        tests++; if (cor !== 4'b0000) begin fails++; $display("FAIL flip1_corners: got %b expected 0000", cor); end
        tests++; if (mid !== 16'h000A) begin fails++; $display("FAIL flip1_row1_update: got %h expected 000a", mid); end
        tests++; if (fin !== 16'h0A0A) begin fails++; $display("FAIL flip1_m_out: got %h expected 0a0a", fin); end
        tests++; if (cnt !== 16'd1) begin fails++; $display("FAIL flip1_cnt: got %0d expected 1", cnt); end
        @(posedge clk); #1;
        model_op(1'b0, 0, 2, 1, 3, e_lat, e_err, e_cor, e_mid, e_fin, e_cnt);
        run_op(1'b0, 0, 2, 1, 3, lat, err, cor, mid, fin, cnt);
        tests++; if (lat !== 3) begin fails++; $display("FAIL flip2_latency: got %0d expected 3", lat); end
        tests++; if (cor !== 4'b1111) begin fails++; $display("FAIL flip2_corners: got %b expected 1111", cor); end
        tests++; if (mid !== 16'h0A00) begin fails++; $display("FAIL flip2_row1_update: got %h expected 0a00", mid); end
        tests++; if (fin !== 16'h0000) begin fails++; $display("FAIL flip2_m_out: got %h expected 0000", fin); end
        tests++; if (cnt !== 16'd2) begin fails++; $display("FAIL flip2_cnt: got %0d expected 2", cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_test_op();
        int lat, e_lat; logic err, e_err; logic [3:0] cor, e_cor;
        logic [15:0] mid, e_mid, fin, e_fin, cnt, e_cnt;
        do_load(16'h0A0A);
        model_op(1'b1, 0, 2, 1, 3, e_lat, e_err, e_cor, e_mid, e_fin, e_cnt);
        run_op(1'b1, 0, 2, 1, 3, lat, err, cor, mid, fin, cnt);
        tests++; if (lat !== 3) begin fails++; $display("FAIL test_latency: got %0d expected 3", lat); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL test_err: got %b expected 0", err); end
        tests++; if (cor !== 4'b1111) begin fails++; $display("FAIL test_corners: got %b expected 1111", cor); end
        tests++; if (mid !== 16'h0A0A) begin fails++; $display("FAIL test_mid_m_out: got %h expected 0a0a", mid); end
        tests++; if (fin !== 16'h0A0A) begin fails++; $display("FAIL test_m_out: got %h expected 0a0a", fin); end
        tests++; if (cnt !== 16'd2) begin fails++; $display("FAIL test_cnt: got %0d expected 2", cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_invalid();
        int lat, e_lat; logic err, e_err; logic [3:0] cor, e_cor;
        logic [15:0] mid, e_mid, fin, e_fin, cnt, e_cnt;
        model_op(1'b0, 1, 1, 0, 3, e_lat, e_err, e_cor, e_mid, e_fin, e_cnt);
        run_op(1'b0, 1, 1, 0, 3, lat, err, cor, mid, fin, cnt);
        tests++; if (lat !== 1) begin fails++; $display("FAIL inv_row_latency: got %0d expected 1", lat); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL inv_row_err: got %b expected 1", err); end
        tests++; if (cor !== 4'b0000) begin fails++; $display("FAIL inv_row_corners: got %b expected 0000", cor); end
        tests++; if (fin !== 16'h0A0A) begin fails++; $display("FAIL inv_row_m_out: got %h expected 0a0a", fin); end
        tests++; if (cnt !== 16'd2) begin fails++; $display("FAIL inv_row_cnt: got %0d expected 2", cnt); end
        @(posedge clk); #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL inv_pulse_width: got %b expected 0", rsp_valid); end
        tests++; if (rsp_err !== 1'b1) begin fails++; $display("FAIL inv_err_hold: got %b expected 1", rsp_err); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL inv_back_to_idle: got %b expected 1", req_ready); end
        model_op(1'b0, 0, 3, 2, 2, e_lat, e_err, e_cor, e_mid, e_fin, e_cnt);
        run_op(1'b0, 0, 3, 2, 2, lat, err, cor, mid, fin, cnt);
        tests++; if (lat !== 1) begin fails++; $display("FAIL inv_col_latency: got %0d expected 1", lat); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL inv_col_err: got %b expected 1", err); end
        tests++; if (fin !== 16'h0A0A) begin fails++; $display("FAIL inv_col_m_out: got %h expected 0a0a", fin); end
        @(posedge clk); #1;
    endtask

    task automatic test_load_priority();
        int lat, e_lat; logic err, e_err; logic [3:0] cor, e_cor;
        logic [15:0] mid, e_mid, fin, e_fin, cnt, e_cnt;
        load_valid = 1'b1; load_matrix = 16'h1234;
        req_op = 1'b0; req_r1 = 2'd1; req_r2 = 2'd3; req_c1 = 2'd0; req_c2 = 2'd2;
        req_valid = 1'b1;
        #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL load_prio_ready: got %b expected 0", req_ready); end
        @(posedge clk); #1;
        load_valid = 1'b0;
        tests++; if (m_out !== 16'h1234) begin fails++; $display("FAIL load_prio_loaded: got %h expected 1234", m_out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL load_prio_not_accepted: got busy=%b expected 0", busy); end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mm[r][c] = load_matrix[r*4+c];
        model_op(1'b0, 1, 3, 0, 2, e_lat, e_err, e_cor, e_mid, e_fin, e_cnt);
        run_op(1'b0, 1, 3, 0, 2, lat, err, cor, mid, fin, cnt);
        tests++; if (lat !== 3) begin fails++; $display("FAIL load_prio_latency: got %0d expected 3", lat); end
        tests++; if (cor !== 4'b0101) begin fails++; $display("FAIL load_prio_corners: got %b expected 0101", cor); end
        tests++; if (fin !== 16'h4264) begin fails++; $display("FAIL load_prio_m_out: got %h expected 4264", fin); end
        tests++; if (cnt !== 16'd3) begin fails++; $display("FAIL load_prio_cnt: got %0d expected 3", cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int e_lat; logic e_err; logic [3:0] e_cor;
        logic [15:0] e_mid, e_fin, e_cnt;
        model_op(1'b0, 0, 1, 0, 1, e_lat, e_err, e_cor, e_mid, e_fin, e_cnt);
        req_op = 1'b0; req_r1 = 2'd0; req_r2 = 2'd1; req_c1 = 2'd0; req_c2 = 2'd1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b1; load_matrix = 16'hFFFF;
        req_op = 1'b1; req_r1 = 2'd2; req_r2 = 2'd3; req_c1 = 2'd2; req_c2 = 2'd3;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL busy_ready: got %b expected 0", req_ready); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_flag: got %b expected 1", busy); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL busy_rsp_valid: got %b expected 1", rsp_valid); end
        tests++; if (rsp_corners !== e_cor) begin fails++; $display("FAIL busy_corners: got %b expected %b", rsp_corners, e_cor); end
        tests++; if (m_out !== e_fin) begin fails++; $display("FAIL busy_m_out: got %h expected %h", m_out, e_fin); end
        tests++; if (flip_cnt !== e_cnt) begin fails++; $display("FAIL busy_cnt: got %0d expected %0d", flip_cnt, e_cnt); end
        load_valid = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (m_out !== e_fin) begin fails++; $display("FAIL busy_after_m_out: got %h expected %h", m_out, e_fin); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_op();
        req_op = 1'b0; req_r1 = 2'd0; req_r2 = 2'd3; req_c1 = 2'd0; req_c2 = 2'd3;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_rsp_valid: got %b expected 0", rsp_valid); end
        tests++; if (m_out !== 16'h0) begin fails++; $display("FAIL rstmid_m_out: got %h expected 0000", m_out); end
        tests++; if (flip_cnt !== 16'h0) begin fails++; $display("FAIL rstmid_cnt: got %0d expected 0", flip_cnt); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b expected 1", req_ready); end
        tests++; if (rsp_corners !== 4'h0) begin fails++; $display("FAIL rstmid_corners: got %b expected 0000", rsp_corners); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_no_late_rsp: got %b expected 0", rsp_valid); end
        model_reset();
    endtask

    task automatic test_small_instance();
        int lat; logic err; logic [3:0] cor; logic [11:0] fin; logic [1:0] cnt;
        logic [3:0] e_cor; logic [11:0] e_fin; logic [1:0] e_cnt;
        s_load_valid = 1'b1; s_load_matrix = 12'h000;
        @(posedge clk); #1;
        s_load_valid = 1'b0;
        run_op_small(1'b0, 0, 3, 0, 1, lat, err, cor, fin, cnt);
        tests++; if (lat !== 1) begin fails++; $display("FAIL small_r2_range_latency: got %0d expected 1", lat); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL small_r2_range_err: got %b expected 1", err); end
        tests++; if (fin !== 12'h000) begin fails++; $display("FAIL small_r2_range_m_out: got %h expected 000", fin); end
        tests++; if (cnt !== 2'd0) begin fails++; $display("FAIL small_r2_range_cnt: got %0d expected 0", cnt); end
        @(posedge clk); #1;
        run_op_small(1'b0, 3, 1, 2, 1, lat, err, cor, fin, cnt);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL small_r1_range_err: got %b expected 1", err); end
        @(posedge clk); #1;
        // Corners (0,0),(0,3),(2,0),(2,3) occupy bits 0,3,8,11.
        for (int k = 1; k <= 4; k++) begin
            e_cor = (k % 2 == 1) ? 4'b0000 : 4'b1111;
            e_fin = (k % 2 == 1) ? 12'h909 : 12'h000;
            e_cnt = (k >= 3) ? 2'd3 : 2'(k);
            run_op_small(1'b0, 0, 2, 0, 3, lat, err, cor, fin, cnt);
            tests++; if (lat !== 3) begin fails++; $display("FAIL small_flip%0d_latency: got %0d expected 3", k, lat); end
            tests++; if (cor !== e_cor) begin fails++; $display("FAIL small_flip%0d_corners: got %b expected %b", k, cor, e_cor); end
            tests++; if (fin !== e_fin) begin fails++; $display("FAIL small_flip%0d_m_out: got %h expected %h", k, fin, e_fin); end
            tests++; if (cnt !== e_cnt) begin fails++; $display("FAIL small_flip%0d_cnt_sat: got %0d expected %0d", k, cnt, e_cnt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_back_to_back();
        int lat, e_lat; logic err, e_err; logic [3:0] cor, e_cor;
        logic [15:0] mid, e_mid, fin, e_fin, cnt, e_cnt;
        bit op; int r1, r2, c1, c2;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) do_load(16'($urandom));
            op = 1'($urandom_range(0, 1));
            r1 = $urandom_range(0, 3); r2 = $urandom_range(0, 3);
            c1 = $urandom_range(0, 3); c2 = $urandom_range(0, 3);
            model_op(op, r1, r2, c1, c2, e_lat, e_err, e_cor, e_mid, e_fin, e_cnt);
            run_op(op, r1, r2, c1, c2, lat, err, cor, mid, fin, cnt);
            tests++; if (lat !== e_lat) begin fails++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, e_lat); end
            tests++; if (err !== e_err) begin fails++; $display("FAIL rnd%0d_err: got %b expected %b", n, err, e_err); end
            tests++; if (cor !== e_cor) begin fails++; $display("FAIL rnd%0d_corners: got %b expected %b", n, cor, e_cor); end
            tests++; if (mid !== e_mid) begin fails++; $display("FAIL rnd%0d_row1_m_out: got %h expected %h", n, mid, e_mid); end
            tests++; if (fin !== e_fin) begin fails++; $display("FAIL rnd%0d_m_out: got %h expected %h", n, fin, e_fin); end
            tests++; if (cnt !== e_cnt) begin fails++; $display("FAIL rnd%0d_cnt: got %0d expected %0d", n, cnt, e_cnt); end
            @(posedge clk); #1;
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rnd%0d_pulse: got %b expected 0", n, rsp_valid); end
            tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rnd%0d_next_ready: got %b expected 1", n, req_ready); end
            tests++; if (rsp_corners !== e_cor) begin fails++; $display("FAIL rnd%0d_corners_hold: got %b expected %b", n, rsp_corners, e_cor); end
            tests++; if (rsp_err !== e_err) begin fails++; $display("FAIL rnd%0d_err_hold: got %b expected %b", n, rsp_err, e_err); end
        end
    endtask

    initial begin
        test_reset();
        test_flip_directed();
        test_test_op();
        test_invalid();
        test_load_priority();
        test_busy_ignore();
        test_reset_mid_op();
        test_small_instance();
        test_random_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
